// File: rtl/viterbi_dec_k3.sv
// rtl/viterbi_dec_k3.sv - hard-decision K=3 rate-1/2 Viterbi decoder with register-exchange survivors
module viterbi_dec_k3 #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_decoder_i,
    input  logic [1:0] decoder_i,
    output logic       decoder_o,
    output logic       valid_o
);
    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);
    localparam logic [PM_W:0]    PM_HALF  = {2'b01, {(PM_W-1){1'b0}}};
    localparam logic [PM_W:0]    PM_MAX   = {1'b0, {PM_W{1'b1}}};
    localparam logic [PM_W-1:0]  PM_INIT  = {3'b000, 1'b1, {(PM_W-4){1'b0}}};

    logic [PM_W-1:0]     pm      [4];
    logic [TB_DEPTH-1:0] sr      [4];
    logic [CNT_W-1:0]    cnt;
    logic                en_d1;
    logic [PM_W-1:0]     pm_next [4];
    logic [TB_DEPTH-1:0] sr_next [4];
    logic [PM_W:0]       acs_m   [4];
    logic [1:0]          best;
    logic                out_valid;

    // Hamming distance between the received pair and the symbol emitted from state p on input u
    function automatic logic [PM_W:0] branch_metric(input logic [1:0] p, input logic u,
                                                    input logic [1:0] rx);
        logic c0;
        logic c1;
        c0 = u ^ p[1] ^ p[0];
        c1 = u ^ p[0];
        return {{PM_W{1'b0}}, c0 ^ rx[1]} + {{PM_W{1'b0}}, c1 ^ rx[0]};
    endfunction

    // Add-compare-select into each next state {b, x}; ties keep the even predecessor, then a shared rebase
    always_comb begin
        logic [1:0]    ns_v;
        logic [1:0]    p0;
        logic [1:0]    p1;
        logic [PM_W:0] cand0;
        logic [PM_W:0] cand1;
        logic [PM_W:0] adj;
        logic          all_high;
        ns_v     = '0;
        p0       = '0;
        p1       = '0;
        cand0    = '0;
        cand1    = '0;
        adj      = '0;
        all_high = 1'b1;
        for (int ns = 0; ns < 4; ns++) begin
            acs_m[ns]   = '0;
            sr_next[ns] = '0;
            pm_next[ns] = '0;
        end
        for (int ns = 0; ns < 4; ns++) begin
            ns_v  = 2'(ns);
            p0    = {ns_v[0], 1'b0};
            p1    = {ns_v[0], 1'b1};
            cand0 = {1'b0, pm[p0]} + branch_metric(p0, ns_v[1], decoder_i);
            cand1 = {1'b0, pm[p1]} + branch_metric(p1, ns_v[1], decoder_i);
            if (cand1 < cand0) begin
                acs_m[ns]   = cand1;
                sr_next[ns] = {sr[p1][TB_DEPTH-2:0], ns_v[1]};
            end else begin
                acs_m[ns]   = cand0;
                sr_next[ns] = {sr[p0][TB_DEPTH-2:0], ns_v[1]};
            end
            if (acs_m[ns] < PM_HALF) begin
                all_high = 1'b0;
            end
        end
        for (int ns = 0; ns < 4; ns++) begin
            adj         = all_high ? (acs_m[ns] - PM_HALF) : acs_m[ns];
            pm_next[ns] = (adj > PM_MAX) ? {PM_W{1'b1}} : adj[PM_W-1:0];
        end
    end

    // Best state from registered metrics; the lowest index wins a tie
    always_comb begin
        best = 2'd0;
        for (int s = 1; s < 4; s++) begin
            if (pm[s] < pm[best]) begin
                best = 2'(s);
            end
        end
    end

    assign out_valid = en_d1 && (cnt == CNT_FULL);

    // Trellis state advances only on accepted symbols; the output stage registers every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) begin
                pm[s] <= (s == 0) ? '0 : PM_INIT;
                sr[s] <= '0;
            end
            cnt       <= '0;
            en_d1     <= 1'b0;
            decoder_o <= 1'b0;
            valid_o   <= 1'b0;
        end else begin
            en_d1     <= enable_decoder_i;
            valid_o   <= out_valid;
            decoder_o <= out_valid & sr[best][TB_DEPTH-1];
            if (enable_decoder_i) begin
                for (int s = 0; s < 4; s++) begin
                    pm[s] <= pm_next[s];
                    sr[s] <= sr_next[s];
                end
                if (cnt != CNT_FULL) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_viterbi_dec_k3.sv
// tb/tb_viterbi_dec_k3.sv - self-checking bench for viterbi_dec_k3 against a path-history Viterbi model
module tb_viterbi_dec_k3;
    localparam int TBD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] sym = 2'b00;
    logic       dec8, val8, dec6, val6;

    always #5 clk = ~clk;

    viterbi_dec_k3 #(.TB_DEPTH(TBD), .PM_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .enable_decoder_i(en), .decoder_i(sym),
        .decoder_o(dec8), .valid_o(val8)
    );

    viterbi_dec_k3 #(.TB_DEPTH(TBD), .PM_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .enable_decoder_i(en), .decoder_i(sym),
        .decoder_o(dec6), .valid_o(val6)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: index 0 models PM_W=8, index 1 models PM_W=6
    int  m_pm   [2][4];
    bit  m_hist [2][4][$];
    int  m_cnt;
    bit  m_en_d1;
    int  m_norm [2];
    int  d_norm [2];

    bit [1:0] enc_st;
    bit       out8[$];
    bit       out6[$];
    bit       vtrace[$];
    bit       src[$];

    function automatic int pm_init(int k);
        return (k == 0) ? 16 : 4;
    endfunction

    function automatic int pm_half(int k);
        return (k == 0) ? 128 : 32;
    endfunction

    function automatic int best_of(int k);
        int b;
        b = 0;
        for (int s = 1; s < 4; s++) if (m_pm[k][s] < m_pm[k][b]) b = s;
        return b;
    endfunction

    function automatic int dut_min(int k);
        int mn;
        mn = 1 << 20;
        for (int i = 0; i < 4; i++) begin
            if (k == 0) begin
                if (int'(u_dut8.pm[i]) < mn) mn = int'(u_dut8.pm[i]);
            end else begin
                if (int'(u_dut6.pm[i]) < mn) mn = int'(u_dut6.pm[i]);
            end
        end
        return mn;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 4; s++) begin
                m_pm[k][s] = (s == 0) ? 0 : pm_init(k);
                m_hist[k][s].delete();
            end
        end
        m_cnt   = 0;
        m_en_d1 = 1'b0;
    endtask

    // Forward trellis walk: every (state, input) edge offers a cost; strict < keeps the lower predecessor
    task automatic model_accept(input bit [1:0] rx);
        int       nm [4];
        bit       nh [4][$];
        bit [1:0] sb;
        bit       c0, c1;
        int       ns, cost;
        bit       all_hi;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                nm[i] = 1 << 30;
                nh[i].delete();
            end
            for (int s = 0; s < 4; s++) begin
                for (int u = 0; u < 2; u++) begin
                    sb   = 2'(s);
                    c0   = bit'(u) ^ sb[1] ^ sb[0];
                    c1   = bit'(u) ^ sb[0];
                    ns   = u * 2 + int'(sb[1]);
                    cost = m_pm[k][s] + $countones(rx ^ {c0, c1});
                    if (cost < nm[ns]) begin
                        nm[ns] = cost;
                        nh[ns] = m_hist[k][s];
                        nh[ns].push_back(bit'(u));
                        if (nh[ns].size() > TBD) void'(nh[ns].pop_front());
                    end
                end
            end
            all_hi = 1'b1;
            for (int i = 0; i < 4; i++) if (nm[i] < pm_half(k)) all_hi = 1'b0;
            if (all_hi) begin
                for (int i = 0; i < 4; i++) nm[i] -= pm_half(k);
                m_norm[k]++;
            end
            for (int i = 0; i < 4; i++) begin
                m_pm[k][i]   = nm[i];
                m_hist[k][i] = nh[i];
            end
        end
        if (m_cnt < TBD) m_cnt++;
    endtask

    // One clock edge: predict outputs from pre-edge model state, drive, advance model, compare
    task automatic step(input bit r, input bit e, input bit [1:0] s);
        bit ev;
        bit ed [2];
        int pre [2];
        ev = m_en_d1 && (m_cnt == TBD);
        for (int k = 0; k < 2; k++) begin
            ed[k] = 1'b0;
            if (ev) ed[k] = m_hist[k][best_of(k)][0];
        end
        pre[0] = dut_min(0);
        pre[1] = dut_min(1);
        rst = r;
        en  = e;
        sym = s;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_en_d1 = e;
            if (e) model_accept(s);
        end
        #1;
        chk("valid8", val8, ev);
        chk("dec8", dec8, ed[0]);
        chk("valid6", val6, ev);
        chk("dec6", dec6, ed[1]);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pm8[%0d]", i), u_dut8.pm[i], m_pm[0][i]);
            chk($sformatf("pm6[%0d]", i), u_dut6.pm[i], m_pm[1][i]);
        end
        if (!r) begin
            if (dut_min(0) < pre[0]) d_norm[0]++;
            if (dut_min(1) < pre[1]) d_norm[1]++;
        end
        if (val8) out8.push_back(dec8);
        if (val6) out6.push_back(dec6);
        vtrace.push_back(val8);
    endtask

    task automatic send_sym(input bit [1:0] s);
        step(1'b0, 1'b1, s);
    endtask

    task automatic send_bit(input bit u, input bit flip);
        bit [1:0] c;
        c      = {u ^ enc_st[1] ^ enc_st[0], u ^ enc_st[0]};
        enc_st = {u, enc_st[1]};
        if (flip) c ^= ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        step(1'b0, 1'b1, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'($urandom_range(0, 3)));
    endtask

    task automatic clear_seg();
        enc_st = 2'b00;
        out8.delete();
        out6.delete();
        vtrace.delete();
        src.delete();
    endtask

    task automatic restart();
        step(1'b1, 1'b0, 2'b00);
        clear_seg();
    endtask

    function automatic int first_valid();
        for (int i = 0; i < vtrace.size(); i++) if (vtrace[i]) return i;
        return -1;
    endfunction

    function automatic int src_mism();
        int n;
        n = 0;
        for (int i = 0; i < src.size(); i++) begin
            if (i >= out8.size() || out8[i] != src[i]) n++;
            if (i >= out6.size() || out6[i] != src[i]) n++;
        end
        return n;
    endfunction

    bit [21:0] known_syms;
    bit [10:0] known_bits;
    int        ones, lows, fv, lv;

    initial begin
        known_syms = 22'b11_10_11_11_01_01_11_00_11_01_10;
        known_bits = 11'b10011000111;
        m_norm[0] = 0; m_norm[1] = 0;
        d_norm[0] = 0; d_norm[1] = 0;
        model_reset();

        // Reset state
        restart();
        idle(2);

        // All-zero stream
        restart();
        for (int i = 0; i < 64; i++) send_sym(2'b00);
        idle(1);
        chk("zero_count8", out8.size(), 49);
        chk("zero_count6", out6.size(), 49);
        ones = 0;
        foreach (out8[i]) if (out8[i]) ones++;
        chk("zero_ones", ones, 0);
        chk("zero_first_valid", first_valid(), TBD);
        chk("zero_pm0", u_dut8.pm[0], 0);

        // Known sequence with flush
        restart();
        for (int i = 0; i < 11; i++) begin
            send_sym(known_syms[21-2*i -: 2]);
            src.push_back(known_bits[10-i]);
        end
        enc_st = 2'b11;
        for (int i = 0; i < TBD; i++) send_bit(1'b0, 1'b0);
        idle(1);
        chk("known_mism", src_mism(), 0);
        chk("known_latency", first_valid(), TBD);
        chk("known_count", out8.size(), 27 - 15);

        // Error correction: one flipped bit in every 8th pair
        restart();
        for (int i = 0; i < 200; i++) begin
            src.push_back(bit'($urandom_range(0, 1)));
            send_bit(src[i], (i % 8) == 7);
        end
        for (int i = 0; i < TBD; i++) send_bit(1'b0, 1'b0);
        idle(1);
        chk("ecc_count", out8.size(), 216 - 15);
        chk("ecc_mism", src_mism(), 0);

        // Enable gaps, including one after the counter has saturated
        restart();
        for (int i = 0; i < 11; i++) begin
            send_sym(known_syms[21-2*i -: 2]);
            src.push_back(known_bits[10-i]);
            if (i == 2 || i == 7) idle(3);
        end
        enc_st = 2'b11;
        for (int i = 0; i < TBD; i++) begin
            send_bit(1'b0, 1'b0);
            if (i == 5) idle(2);
        end
        idle(1);
        chk("gap_mism", src_mism(), 0);
        chk("gap_count", out8.size(), 27 - 15);
        fv = first_valid();
        lv = -1;
        for (int i = 0; i < vtrace.size(); i++) if (vtrace[i]) lv = i;
        lows = 0;
        for (int i = fv; i >= 0 && i <= lv; i++) if (!vtrace[i]) lows++;
        chk("gap_idle_lows", lows, 2);

        // Reset mid-stream with a symbol presented alongside rst
        restart();
        for (int i = 0; i < 11; i++) send_bit(bit'($urandom_range(0, 1)), 1'b0);
        step(1'b1, 1'b1, 2'($urandom_range(0, 3)));
        chk("rst_valid_next", val8, 1'b0);
        clear_seg();
        for (int i = 0; i < 29; i++) begin
            src.push_back(bit'($urandom_range(0, 1)));
            send_bit(src[i], 1'b0);
        end
        for (int i = 0; i < TBD; i++) send_bit(1'b0, 1'b0);
        idle(1);
        ones = 0;
        for (int i = 0; i < TBD; i++) if (vtrace[i]) ones++;
        chk("rst_refill_quiet", ones, 0);
        chk("rst_count", out8.size(), 45 - 15);
        chk("rst_mism", src_mism(), 0);

        // Long run with an error in every 6th pair to force metric rebasing
        restart();
        m_norm[0] = 0; m_norm[1] = 0;
        d_norm[0] = 0; d_norm[1] = 0;
        for (int i = 0; i < 5000; i++) begin
            src.push_back(bit'($urandom_range(0, 1)));
            send_bit(src[i], (i % 6) == 5);
        end
        for (int i = 0; i < TBD; i++) send_bit(1'b0, 1'b0);
        idle(1);
        chk("norm_count", out8.size(), 5016 - 15);
        chk("norm_mism", src_mism(), 0);
        chk("norm6_seen", d_norm[1] > 0, 1);
        chk("norm6_events", d_norm[1], m_norm[1]);
        chk("norm8_events", d_norm[0], m_norm[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
